// File: rtl/einsum_red_seq.sv
// Sequential log-space reduction controller: streams elements into an external adder and returns the sum.
// Optional busy-cycle counter output o_cycles is built when EINSUM_RED_PERF_CNT_EN is defined.
module einsum_red_seq #(
  parameter int LEN_W  = 8,
  parameter int WORD_W = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_elem_valid,
  output logic              o_elem_ready,
  input  logic [WORD_W-1:0] i_elem,
  output logic              o_add_en,
  output logic              o_add_bypass,
  output logic [WORD_W-1:0] o_operand_a,
  output logic [WORD_W-1:0] o_operand_b,
  input  logic [WORD_W-1:0] i_add_sum,
  output logic              o_result_valid,
  input  logic              i_result_ready,
  output logic [WORD_W-1:0] o_result,
  output logic              o_busy,
`ifdef EINSUM_RED_PERF_CNT_EN
  output logic [15:0]       o_cycles,
`endif
  output logic [1:0]        o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               first_q, first_d;
  logic [WORD_W-1:0]  result_q, result_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      first_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      first_q  <= first_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    first_d  = first_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            rem_d   = i_len;
            first_d = 1'b1;
            state_d = S_ISSUE;
          end else begin
            result_d = '0;
            state_d  = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (i_elem_valid) begin
          first_d = 1'b0;
          rem_d   = rem_q - LEN_W'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The adder's registered sum for the element just issued is visible here.
        if (rem_q == '0) begin
          result_d = i_add_sum;
          state_d  = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        if (i_result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_elem_ready   = 1'b0;
    o_add_en       = 1'b0;
    o_add_bypass   = 1'b0;
    o_operand_a    = '0;
    o_operand_b    = '0;
    o_result_valid = 1'b0;
    case (state_q)
      S_ISSUE: begin
        o_elem_ready = 1'b1;
        if (i_elem_valid) begin
          o_add_en     = 1'b1;
          o_add_bypass = first_q;
          o_operand_a  = i_elem;
          o_operand_b  = i_add_sum;
        end
      end
      S_DONE:  o_result_valid = 1'b1;
      default: ;
    endcase
  end

  assign o_result    = result_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_dbg_state = state_q;

`ifdef EINSUM_RED_PERF_CNT_EN
  logic [15:0] cycles_q, cycles_d;

  // Starts at 1 so the first busy cycle is counted; DONE holds the final count.
  always_comb begin
    cycles_d = cycles_q;
    if (state_q == S_IDLE) begin
      if (i_start) cycles_d = 16'd1;
    end else if (state_q == S_ISSUE || state_q == S_WAIT) begin
      if (cycles_q != 16'hFFFF) cycles_d = cycles_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cycles_q <= '0;
    else       cycles_q <= cycles_d;
  end

  assign o_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_einsum_red_seq.sv
// Bench for einsum_red_seq: table of reductions plus reset/backpressure sequences, with a plain-add adder model.
module tb_einsum_red_seq;
  localparam int LEN_W = 8;
  localparam int W     = 24;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic             i_elem_valid;
  logic             o_elem_ready;
  logic [W-1:0]     i_elem;
  logic             o_add_en;
  logic             o_add_bypass;
  logic [W-1:0]     o_operand_a;
  logic [W-1:0]     o_operand_b;
  logic [W-1:0]     i_add_sum;
  logic             o_result_valid;
  logic             i_result_ready;
  logic [W-1:0]     o_result;
  logic             o_busy;
  logic [1:0]       o_dbg_state;
`ifdef EINSUM_RED_PERF_CNT_EN
  logic [15:0]      o_cycles;
`endif

  einsum_red_seq #(.LEN_W(LEN_W), .WORD_W(W)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_len          (i_len),
    .i_elem_valid   (i_elem_valid),
    .o_elem_ready   (o_elem_ready),
    .i_elem         (i_elem),
    .o_add_en       (o_add_en),
    .o_add_bypass   (o_add_bypass),
    .o_operand_a    (o_operand_a),
    .o_operand_b    (o_operand_b),
    .i_add_sum      (i_add_sum),
    .o_result_valid (o_result_valid),
    .i_result_ready (i_result_ready),
    .o_result       (o_result),
    .o_busy         (o_busy),
`ifdef EINSUM_RED_PERF_CNT_EN
    .o_cycles       (o_cycles),
`endif
    .o_dbg_state    (o_dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  // Downstream adder stand-in: registered, plain wrap-around add, garbage value after reset.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         i_add_sum <= 24'h5A5A5A;
    else if (o_add_en) i_add_sum <= o_add_bypass ? o_operand_a : (o_operand_a + o_operand_b);
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  int red_id  = 0;
  int last_id = 0;
  int mon_idx = 0;

  task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (red_id != last_id) begin
      last_id = red_id;
      mon_idx = 0;
    end
    if (!i_rst) begin
      chk_b("ready_and_valid_exclusive", o_elem_ready & o_result_valid, 1'b0);
      chk_b("add_en_is_accept", o_add_en, i_elem_valid & o_elem_ready);
      if (!o_add_en) begin
        chk_w("idle_operands_zero", o_operand_a | o_operand_b | W'(o_add_bypass), '0);
      end else begin
        chk_w("operand_a", o_operand_a, i_elem);
        chk_w("operand_b", o_operand_b, i_add_sum);
        chk_b("bypass_first_only", o_add_bypass, mon_idx == 0);
        mon_idx = mon_idx + 1;
      end
      if (o_result_valid && i_result_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got 0x%0h expected none", o_result);
        end else begin
          chk_w("scoreboard_result", o_result, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic feed_elem(input logic [W-1:0] e);
    bit acc;
    acc = 1'b0;
    i_elem_valid = 1'b1;
    i_elem       = e;
    for (int t = 0; t < 8; t++) begin
      #1;
      if (o_elem_ready) begin
        acc = 1'b1;
        break;
      end
      tick();
    end
    chk_b("elem_accept_within_budget", acc, 1'b1);
    tick();
  endtask

  task automatic run_red(input int len, input logic [3:0][W-1:0] elems, input int gap,
                         input int hold, input logic [W-1:0] exp_res);
    logic [W-1:0] held;
    exp_q.push_back(exp_res);
    red_id++;
    i_start = 1'b1;
    i_len   = len[LEN_W-1:0];
    tick();
    i_start = 1'b0;
    chk_b("busy_after_start", o_busy, 1'b1);
    if (len == 0) begin
      chk_b("len0_done_next_cycle", o_result_valid, 1'b1);
      chk_w("len0_result_zero", o_result, '0);
    end else begin
      for (int k = 0; k < len; k++) begin
        for (int g = 0; g < gap; g++) begin
          i_elem_valid = 1'b0;
          i_start      = 1'b1;
          i_len        = '0;
          tick();
        end
        i_start = 1'b0;
        feed_elem(elems[k]);
      end
      i_elem_valid = 1'b0;
      #1;
      chk_b("no_valid_in_wait", o_result_valid, 1'b0);
      tick();
      chk_b("valid_2_cycles_after_accept", o_result_valid, 1'b1);
    end
    chk_i("add_en_pulse_count", mon_idx, len);
`ifdef EINSUM_RED_PERF_CNT_EN
    if (gap == 0) chk_i("busy_cycle_count", int'(o_cycles), (len == 0) ? 1 : 2 * len + 1);
`endif
    held = o_result;
    for (int h = 0; h < hold; h++) begin
      i_result_ready = 1'b0;
      tick();
      chk_b("valid_held", o_result_valid, 1'b1);
      chk_w("result_stable", o_result, held);
    end
    i_result_ready = 1'b1;
    tick();
    i_result_ready = 1'b0;
    #1;
    chk_b("valid_drops_after_ready", o_result_valid, 1'b0);
    chk_b("idle_after_ready", o_busy, 1'b0);
  endtask

  typedef struct packed {
    logic [7:0]         len;
    logic [3:0][W-1:0]  elems;
    logic [7:0]         gap;
    logic [7:0]         hold;
    logic [W-1:0]       exp_result;
  } vec_t;

  vec_t vecs[6];

  task automatic set_vec(input int idx, input int len, input logic [W-1:0] e0, input logic [W-1:0] e1,
                         input logic [W-1:0] e2, input logic [W-1:0] e3, input int gap, input int hold,
                         input logic [W-1:0] exp_res);
    vecs[idx].len        = len[7:0];
    vecs[idx].elems[0]   = e0;
    vecs[idx].elems[1]   = e1;
    vecs[idx].elems[2]   = e2;
    vecs[idx].elems[3]   = e3;
    vecs[idx].gap        = gap[7:0];
    vecs[idx].hold       = hold[7:0];
    vecs[idx].exp_result = exp_res;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][W-1:0] rel;
    logic [W-1:0]      rsum;
    int                rlen;

    i_rst = 1'b1;
    i_start = 1'b0;
    i_len = '0;
    i_elem_valid = 1'b0;
    i_elem = '0;
    i_result_ready = 1'b0;

    set_vec(0, 1, 24'h000100, 24'h0,      24'h0,      24'h0,      0, 0, 24'h000100);
    set_vec(1, 3, 24'h000010, 24'h000020, 24'h000030, 24'h0,      0, 0, 24'h000060);
    set_vec(2, 0, 24'h0,      24'h0,      24'h0,      24'h0,      0, 1, 24'h000000);
    set_vec(3, 2, 24'h001000, 24'h000234, 24'h0,      24'h0,      4, 3, 24'h001234);
    set_vec(4, 4, 24'h100000, 24'h200000, 24'h300000, 24'hF00001, 1, 1, 24'h500001);
    set_vec(5, 2, 24'hFFFFFF, 24'h000002, 24'h0,      24'h0,      0, 2, 24'h000001);

    #12;
    chk_b("reset_busy", o_busy, 1'b0);
    chk_b("reset_elem_ready", o_elem_ready, 1'b0);
    chk_b("reset_result_valid", o_result_valid, 1'b0);
    chk_w("reset_result", o_result, '0);
    chk_w("reset_state", W'(o_dbg_state), '0);
    i_rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_red(int'(vecs[i].len), vecs[i].elems, int'(vecs[i].gap), int'(vecs[i].hold), vecs[i].exp_result);
      tick();
    end

    // Reset in the middle of a four-element reduction; nothing may come out of it.
    red_id++;
    i_start = 1'b1;
    i_len   = 8'd4;
    tick();
    i_start = 1'b0;
    feed_elem(24'h000011);
    feed_elem(24'h000022);
    #2;
    i_rst = 1'b1;
    #1;
    chk_b("midrst_busy", o_busy, 1'b0);
    chk_b("midrst_elem_ready", o_elem_ready, 1'b0);
    chk_b("midrst_add_en", o_add_en, 1'b0);
    chk_w("midrst_operands", o_operand_a | o_operand_b | W'(o_add_bypass), '0);
    chk_b("midrst_result_valid", o_result_valid, 1'b0);
    chk_w("midrst_result", o_result, '0);
    chk_w("midrst_state", W'(o_dbg_state), '0);
    tick();
    tick();
    i_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_b("postrst_no_ready", o_elem_ready, 1'b0);
      chk_b("postrst_no_result", o_result_valid, 1'b0);
    end
    i_elem_valid = 1'b0;
    chk_i("postrst_no_extra_accepts", mon_idx, 2);
    rel = '0;
    rel[0] = 24'h000777;
    run_red(1, rel, 0, 0, 24'h000777);
    tick();

    // Random reductions with the expected sum built here.
    for (int r = 0; r < 4; r++) begin
      rlen = $urandom_range(1, 4);
      rel  = '0;
      rsum = '0;
      for (int k = 0; k < rlen; k++) begin
        rel[k] = W'($urandom_range(0, 32'h00FFFFFF));
        rsum   = rsum + rel[k];
      end
      run_red(rlen, rel, $urandom_range(0, 2), $urandom_range(0, 2), rsum);
      tick();
    end

    chk_i("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/einsum_red_seq.md
EINSUM_RED_SEQ -- requirements
Module: einsum_red_seq

Interface
REQ-001 Parameter: LEN_W, default 8, width of the reduction-length input and element counter.
REQ-002 Port: i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: i_rst  input  1  asynchronous, active-high reset.
REQ-004 Port: i_start  input  1  request to begin one reduction; sampled only in IDLE.
REQ-005 Port: i_len  input  LEN_W  number of elements to reduce, captured with i_start.
REQ-006 Port: i_elem_valid / o_elem_ready  input / output  1 / 1  element stream handshake.
REQ-007 Port: i_elem  input  word_t  log-space element.
REQ-008 Port: o_add_en, o_add_bypass  output  1 each  enable and bypass to the downstream log-space adder.
REQ-009 Port: o_operand_a, o_operand_b  output  word_t each  adder operands.
REQ-010 Port: i_add_sum  input  word_t  registered adder result, fed back.
REQ-011 Port: o_result_valid / i_result_ready  output / input  1 / 1  result handshake.
REQ-012 Port: o_result  output  word_t  final reduction value.
REQ-013 Port: o_busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT, DONE; one-hot or binary encoding is acceptable.
REQ-015 IDLE: i_start=1 and i_len!=0 -> capture i_len into remaining counter, set first flag, go ISSUE.
REQ-016 IDLE: i_start=1 and i_len==0 -> o_result<=0, go DONE with no adder activity.
REQ-017 ISSUE: o_elem_ready=1; element accepted when i_elem_valid&o_elem_ready in same cycle.
REQ-018 On accept: o_add_en=1, o_operand_a=i_elem, o_operand_b=i_add_sum, o_add_bypass=first flag (combinational, same cycle); clear first flag, decrement remaining, go WAIT.
REQ-019 ISSUE without i_elem_valid: o_add_en=0, stay ISSUE, no counter change.
REQ-020 WAIT (exactly one cycle, covers the adder's one-cycle register): o_elem_ready=0, o_add_en=0; if remaining==0, o_result<=i_add_sum and go DONE, else go ISSUE.
REQ-021 Throughput: one element per 2 cycles max; latency from last accept to o_result_valid = 2 cycles.
REQ-022 DONE: o_result_valid=1, o_result held stable; on i_result_ready go IDLE (valid drops next cycle).
REQ-023 i_start outside IDLE ignored; i_elem_valid outside ISSUE not accepted.
REQ-024 o_operand_a/o_operand_b/o_add_bypass drive 0 when o_add_en=0.
REQ-025 o_elem_ready and o_result_valid never high in the same cycle.

Reset
REQ-026 i_rst asserted (any time, incl. mid-reduction) -> state IDLE, counter 0, first flag 0, o_result 0, all handshake and adder-control outputs 0, o_busy 0.
REQ-027 A reduction interrupted by reset is discarded; no result issued after deassertion.

Configuration
REQ-028 Macro EINSUM_RED_PERF_CNT_EN defined: add output o_cycles (16 bits) counting cycles with o_busy=1 for the current reduction; cleared on IDLE->ISSUE/DONE transition, saturates at 0xFFFF, held in DONE and IDLE, reset to 0.
REQ-029 Macro undefined: o_cycles port and counter absent; all other behaviour identical.

Verification
REQ-030 i_len=1, elem 0x000100 valid -> o_add_en with bypass=1, operand_a=0x000100; i_add_sum=0x000100 in WAIT -> o_result=0x000100, valid 2 cycles after accept.
REQ-031 i_len=3, elems A,B,C back-to-back -> bypass only on A; operand_b on B and C equals i_add_sum from prior step; exactly 3 o_add_en pulses, result = final i_add_sum.
REQ-032 i_len=0 -> DONE next cycle, o_result=0, no o_add_en pulse.
REQ-033 i_len=2, i_elem_valid gapped 4 cycles between elems, i_result_ready low 3 cycles -> no spurious accepts, o_result stable while held, IDLE one cycle after ready.
REQ-034 i_len=4, i_rst pulsed after 2nd accept -> all outputs 0 immediately, IDLE, no result; new i_start afterwards runs cleanly with bypass on first element.
REQ-035 With EINSUM_RED_PERF_CNT_EN, i_len=2 with no stalls -> o_cycles=5 in DONE (2 ISSUE+2 WAIT+1 DONE).
